vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver_pkg.sv | 21 ++
 rtl/vga_sync_receiver_sync_edge_counter.sv | 67 ++++++
 rtl/vga_sync_receiver.sv | 159 +++++++++++++++
 tb/tb_vga_sync_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_receiver_pkg.sv
// Shared 640x480@60 timing constants and lock-state encoding, common to the
// VGA timing generator and the sync receiver.
package vga_sync_receiver_pkg;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_ACTIVE = 480;

    localparam int               CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_e;
endpackage

// File: rtl/vga_sync_receiver_sync_edge_counter.sv
// Falling-edge detector on an active-low sync, saturating position counter
// advanced by step_i, and low-pulse width measurement in clock cycles.
module sync_edge_counter
    import vga_sync_receiver_pkg::*;
#(
    parameter bit CHECK_LOW = 1'b0,
    parameter int EXP_LOW   = 1
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             sync_i,
    input  logic             step_i,
    output logic             fall_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_prev_o,
    output logic             width_err_o
);
    localparam logic [CNT_W-1:0] EXP_LOW_W = CNT_W'(EXP_LOW);

    logic             sync_prev_q;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] low_w_q, low_w_d;
    logic             rise;
    logic             rearm;

    assign fall_o = sync_prev_q & ~sync_i;
    assign rise   = ~sync_prev_q & sync_i;
    // A falling edge between steps is remembered so the count re-zeroes on the next step.
    assign rearm  = step_i & (fall_o | pending_q);

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        low_w_d   = low_w_q;
        if (rearm) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            if (step_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            if (fall_o) pending_d = 1'b1;
        end
        if (fall_o) begin
            low_w_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!sync_i && (low_w_q != CNT_MAX)) begin
            low_w_d = low_w_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            sync_prev_q <= 1'b1;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            low_w_q     <= '0;
        end else begin
            sync_prev_q <= sync_i;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            low_w_q     <= low_w_d;
        end
    end

    assign cnt_o       = cnt_d;
    assign cnt_prev_o  = cnt_q;
    assign width_err_o = CHECK_LOW && rise && (low_w_q != EXP_LOW_W);
endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: measures incoming h/v sync timing, locks onto a stable
// raster and emits pixel coordinates and colour for the visible area.
module vga_sync_receiver
    import vga_sync_receiver_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic [2:0] color_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic [2:0] pix_color,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [7:0] frame_cnt
);
    localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

    logic             hs_s1_q, vs_s1_q;
    logic [2:0]       color_s1_q;
    logic             h_fall, v_fall, h_width_err, v_width_err;
    logic [CNT_W-1:0] h_cnt, h_cnt_prev, v_cnt, v_cnt_prev;
    lock_state_e      state_q, state_d;
    logic             h_seen_q, h_seen_d;
    logic             acq_bad_q, acq_bad_d;
    logic             any_err;
    logic             pix_valid_q, pix_valid_d;
    logic [9:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [2:0]       pix_color_q, pix_color_d;
    logic             frame_start_q, timing_err_q, timing_err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    sync_edge_counter #(.CHECK_LOW(1'b1), .EXP_LOW(H_SYNC)) u_h_edge (
        .clk        (clk),
        .srst_i     (reset),
        .sync_i     (hs_s1_q),
        .step_i     (1'b1),
        .fall_o     (h_fall),
        .cnt_o      (h_cnt),
        .cnt_prev_o (h_cnt_prev),
        .width_err_o(h_width_err)
    );

    sync_edge_counter #(.CHECK_LOW(1'b0), .EXP_LOW(V_SYNC)) u_v_edge (
        .clk        (clk),
        .srst_i     (reset),
        .sync_i     (vs_s1_q),
        .step_i     (h_fall),
        .fall_o     (v_fall),
        .cnt_o      (v_cnt),
        .cnt_prev_o (v_cnt_prev),
        .width_err_o(v_width_err)
    );

    // Line length is only trusted once a previous h_sync edge has been seen.
    assign any_err = (h_fall && h_seen_q && (h_cnt_prev != H_LAST))
                   || h_width_err || v_width_err
                   || (v_fall && (v_cnt_prev != V_LAST))
                   || (h_cnt == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        acq_bad_d    = acq_bad_q;
        timing_err_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        h_seen_d     = h_fall ? 1'b1 : h_seen_q;
        case (state_q)
            SEARCH: begin
                if (v_fall) begin
                    state_d   = ACQUIRE;
                    acq_bad_d = 1'b0;
                end
            end
            ACQUIRE: begin
                if (v_fall) begin
                    if (!acq_bad_q && !any_err) state_d = LOCKED;
                    acq_bad_d = 1'b0;
                end else if (any_err) begin
                    acq_bad_d = 1'b1;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_d      = SEARCH;
                    timing_err_d = 1'b1;
                    h_seen_d     = 1'b0;
                end else if (v_fall) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: state_d = SEARCH;
        endcase

        pix_valid_d = (state_q == LOCKED)
                   && (h_cnt >= H_START) && (h_cnt < H_END)
                   && (v_cnt >= V_START) && (v_cnt < V_END);
        pix_x_d     = pix_valid_d ? (h_cnt - H_START) : 10'd0;
        pix_y_d     = pix_valid_d ? (v_cnt - V_START) : 10'd0;
        pix_color_d = pix_valid_d ? color_s1_q : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            color_s1_q    <= 3'd0;
            state_q       <= SEARCH;
            h_seen_q      <= 1'b0;
            acq_bad_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_color_q   <= 3'd0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            hs_s1_q       <= h_sync;
            vs_s1_q       <= v_sync;
            color_s1_q    <= color_in;
            state_q       <= state_d;
            h_seen_q      <= h_seen_d;
            acq_bad_q     <= acq_bad_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_color_q   <= pix_color_d;
            frame_start_q <= v_fall;
            timing_err_q  <= timing_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign pix_color   = pix_color_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign timing_err  = timing_err_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down raster (12x5) so that
// lock, error, wrap and reset scenarios fit in a short run.
module tb_vga_sync_receiver;
    localparam int H_TOTAL  = 12;
    localparam int H_SYNC   = 2;
    localparam int H_BACK   = 2;
    localparam int H_ACTIVE = 6;
    localparam int V_TOTAL  = 5;
    localparam int V_SYNC   = 1;
    localparam int V_BACK   = 1;
    localparam int V_ACTIVE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       h_sync, v_sync;
    logic [2:0] color_in;
    logic [9:0] pix_x, pix_y;
    logic       pix_valid;
    logic [2:0] pix_color;
    logic       frame_start, locked, timing_err;
    logic [7:0] frame_cnt;

    int n_cmp      = 0;
    int n_fail     = 0;
    int err_pulses = 0;
    int fs_pulses  = 0;
    int e0;

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .color_in   (color_in),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_color  (pix_color),
        .frame_start(frame_start),
        .locked     (locked),
        .timing_err (timing_err),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic hs, input logic vs, input logic [2:0] col);
        h_sync   = hs;
        v_sync   = vs;
        color_in = col;
        @(posedge clk);
        #1;
        if (timing_err === 1'b1) err_pulses++;
        if (frame_start === 1'b1) fs_pulses++;
    endtask

    task automatic drive_span(input int j0, input int j1, input int hs_low, input bit vs_low);
        for (int j = j0; j < j1; j++)
            tick((j < hs_low) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1, 3'd0);
    endtask

    task automatic drive_line(input int len, input int hs_low, input bit vs_low);
        drive_span(0, len, hs_low, vs_low);
    endtask

    task automatic drive_frame();
        for (int l = 0; l < V_TOTAL; l++)
            drive_line(H_TOTAL, H_SYNC, l < V_SYNC);
    endtask

    function automatic logic [2:0] col_of(input int j);
        case (j)
            3:       return 3'b110;
            4:       return 3'b101;
            9:       return 3'b011;
            10:      return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Outputs after tick j reflect input slot j-1 (S1 stage + output register).
    task automatic pixel_line(input int line);
        bit active;
        active = (line >= V_SYNC + V_BACK) && (line < V_SYNC + V_BACK + V_ACTIVE);
        for (int j = 0; j < H_TOTAL; j++) begin
            tick((j < H_SYNC) ? 1'b0 : 1'b1, (line < V_SYNC) ? 1'b0 : 1'b1, col_of(j));
            if (j == 4) begin
                check("porch_valid", pix_valid, 0);
                check("porch_color", pix_color, 0);
            end
            if (j == 5) begin
                check("first_valid", pix_valid, active);
                check("first_x", pix_x, 0);
                check("first_y", pix_y, active ? line - 2 : 0);
                check("first_color", pix_color, active ? 5 : 0);
            end
            if (j == 10) begin
                check("last_valid", pix_valid, active);
                check("last_x", pix_x, active ? 5 : 0);
                check("last_color", pix_color, active ? 3 : 0);
            end
            if (j == 11) begin
                check("after_valid", pix_valid, 0);
                check("after_x", pix_x, 0);
                check("after_color", pix_color, 0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_x"}, pix_x, 0);
        check({tag, "_pix_y"}, pix_y, 0);
        check({tag, "_pix_color"}, pix_color, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_timing_err"}, timing_err, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick(1'b1, 1'b1, 3'd0);
        check_all_zero("rst");
        reset      = 1'b0;
        err_pulses = 0;
        fs_pulses  = 0;

        // Frame 1: SEARCH -> ACQUIRE
        drive_frame();
        check("f1_locked", locked, 0);
        check("f1_fs_pulses", fs_pulses, 1);

        // Frame 2: lock rises right after the second v_sync falling edge
        drive_span(0, 1, H_SYNC, 1'b1);
        check("f2_pre_lock", locked, 0);
        drive_span(1, 2, H_SYNC, 1'b1);
        check("f2_lock_rise", locked, 1);
        drive_span(2, H_TOTAL, H_SYNC, 1'b1);
        for (int l = 1; l < V_TOTAL; l++) drive_line(H_TOTAL, H_SYNC, 1'b0);
        check("f2_frame_cnt", frame_cnt, 0);

        // Frame 3: first completed locked frame
        drive_frame();
        check("f3_frame_cnt", frame_cnt, 1);
        check("f3_err_pulses", err_pulses, 0);
        check("f3_fs_pulses", fs_pulses, 3);

        // Frame 4: pixel window, coordinates and colour masking
        for (int l = 0; l < V_TOTAL; l++) pixel_line(l);
        check("f4_frame_cnt", frame_cnt, 2);

        // Frame 5: short line while locked
        drive_line(H_TOTAL, H_SYNC, 1'b1);
        drive_line(H_TOTAL - 1, H_SYNC, 1'b0);
        drive_span(0, 1, H_SYNC, 1'b0);
        check("short_err_before", timing_err, 0);
        check("short_locked_before", locked, 1);
        drive_span(1, 2, H_SYNC, 1'b0);
        check("short_err_pulse", timing_err, 1);
        check("short_unlocked", locked, 0);
        drive_span(2, 3, H_SYNC, 1'b0);
        check("short_err_single", timing_err, 0);
        drive_span(3, H_TOTAL, H_SYNC, 1'b0);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        check("short_err_count", err_pulses, 1);
        check("short_frame_cnt", frame_cnt, 3);

        // Frames 6-7: relock
        drive_frame();
        check("relock_acquire", locked, 0);
        drive_frame();
        check("relock_locked", locked, 1);
        check("relock_frame_cnt", frame_cnt, 3);

        // Frame 8: h_sync pulse one cycle short
        drive_line(H_TOTAL, H_SYNC, 1'b1);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        e0 = err_pulses;
        drive_line(H_TOTAL, H_SYNC - 1, 1'b0);
        check("width_err_pulse", err_pulses, e0 + 1);
        check("width_unlocked", locked, 0);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        check("width_frame_cnt", frame_cnt, 4);

        // Frames 9-10 relock, then h_sync stuck high
        drive_frame();
        drive_frame();
        check("pre_timeout_locked", locked, 1);
        e0 = err_pulses;
        repeat (1100) tick(1'b1, 1'b1, 3'd0);
        check("timeout_err_pulse", err_pulses, e0 + 1);
        check("timeout_unlocked", locked, 0);

        // Frames 11-12 relock, then run frame_cnt up to the wrap
        drive_frame();
        drive_frame();
        check("post_timeout_locked", locked, 1);
        check("post_timeout_frame_cnt", frame_cnt, 4);
        for (int f = 0; f < 251; f++) drive_frame();
        check("frame_cnt_255", frame_cnt, 255);
        drive_frame();
        check("frame_cnt_wrap", frame_cnt, 0);
        check("total_err_pulses", err_pulses, 3);

        // Reset in the middle of a visible line
        drive_line(H_TOTAL, H_SYNC, 1'b1);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        for (int j = 0; j < 7; j++) tick((j < H_SYNC) ? 1'b0 : 1'b1, 1'b1, 3'b010);
        check("pre_rst_valid", pix_valid, 1);
        check("pre_rst_x", pix_x, 1);
        check("pre_rst_color", pix_color, 2);
        check("pre_rst_frame_cnt", frame_cnt, 1);
        e0    = err_pulses;
        reset = 1'b1;
        tick(1'b1, 1'b1, 3'b010);
        check_all_zero("midrst");
        tick(1'b1, 1'b1, 3'd0);
        reset = 1'b0;
        drive_span(9, H_TOTAL, H_SYNC, 1'b0);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        drive_line(H_TOTAL, H_SYNC, 1'b0);
        drive_frame();
        check("post_rst_acquire", locked, 0);
        drive_frame();
        check("post_rst_locked", locked, 1);
        check("post_rst_frame_cnt", frame_cnt, 0);
        check("post_rst_no_err", err_pulses, e0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
